// File: rtl/snake_grid_renderer.sv
// snake_grid_renderer
// Pixel renderer for the snake game. It feeds the d_in input of vgac, using the
// row/col/rdn values that vgac produces.
//
// Each frame_start pulse snapshots the game state. The block then rebuilds the
// back copy of a double-buffered cell-occupancy bitmap:
//   - clear one row per cycle,
//   - then set one segment bit per cycle,
//   - then swap the back copy to the front.
// A two-stage pixel pipeline turns x_addr/y_addr/rdn into an RGB444 colour. It reads
// the front bitmap and the state that was promoted at the last swap.
//
// Ports
//   clk           pixel clock
//   rst           asynchronous reset, active-high
//   frame_start   one-cycle pulse at the start of vertical blank
//   game_state    00 RUNNING, 01 DIE, 10 INITIAL, 11 OFF
//   apple_x/_y    apple cell
//   snake_x_flat  segment i at [i*COORD_W +: COORD_W]; segment 0 is the head
//   snake_y_flat  same layout for y
//   snake_length  number of live segments
//   rdn           active-low video-active from vgac
//   x_addr        pixel column
//   y_addr        pixel row
//   pix_color     RGB444 colour, valid 2 cycles after x_addr/y_addr/rdn
//   pix_valid     pix_color belongs to an active pixel
//   busy          bitmap rebuild in progress
module snake_grid_renderer #(
    parameter int unsigned COORD_W   = 5,
    parameter int unsigned GRID_W    = 32,
    parameter int unsigned GRID_H    = 24,
    parameter int unsigned CELL_LOG2 = 4,
    parameter int unsigned MAX_LEN   = 64,
    parameter int unsigned LEN_W     = 7,
    parameter logic [11:0] HEAD_C    = 12'h0f0,
    parameter logic [11:0] BODY_C    = 12'hf00,
    parameter logic [11:0] APPLE_C   = 12'hfff,
    parameter logic [11:0] BG_C      = 12'h000,
    parameter logic [11:0] INIT_C    = 12'h00f,
    parameter logic [11:0] DIE_C     = 12'h888
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic [1:0]                 game_state,
    input  logic [COORD_W-1:0]         apple_x,
    input  logic [COORD_W-1:0]         apple_y,
    input  logic [MAX_LEN*COORD_W-1:0] snake_x_flat,
    input  logic [MAX_LEN*COORD_W-1:0] snake_y_flat,
    input  logic [LEN_W-1:0]           snake_length,
    input  logic                       rdn,
    input  logic [9:0]                 x_addr,
    input  logic [8:0]                 y_addr,
    output logic [11:0]                pix_color,
    output logic                       pix_valid,
    output logic                       busy
);

    localparam int unsigned SEG_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] GS_RUN  = 2'b00;
    localparam logic [1:0] GS_DIE  = 2'b01;
    localparam logic [1:0] GS_INIT = 2'b10;
    localparam logic [1:0] GS_OFF  = 2'b11;

    localparam logic [COORD_W:0]   GRID_W_C = (COORD_W+1)'(GRID_W);
    localparam logic [COORD_W:0]   GRID_H_C = (COORD_W+1)'(GRID_H);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(GRID_H - 1);
    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {StIdle, StClear, StLoad, StSwap} state_e;

    // ------------------------------------------------------------------
    // Snapshot of the game state, taken on frame_start
    // ------------------------------------------------------------------
    logic [1:0]                 snap_state;
    logic [COORD_W-1:0]         snap_ax, snap_ay;
    logic [LEN_W-1:0]           snap_len;
    logic [MAX_LEN*COORD_W-1:0] snap_x_flat, snap_y_flat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_state  <= GS_OFF;
            snap_ax     <= '0;
            snap_ay     <= '0;
            snap_len    <= '0;
            snap_x_flat <= '0;
            snap_y_flat <= '0;
        end else if (frame_start) begin
            snap_state  <= game_state;
            snap_ax     <= apple_x;
            snap_ay     <= apple_y;
            snap_len    <= (snake_length > LEN_MAX) ? LEN_MAX : snake_length;
            snap_x_flat <= snake_x_flat;
            snap_y_flat <= snake_y_flat;
        end
    end

    // Unpack the flat segment buffers with constant indices
    logic [COORD_W-1:0] snap_x_arr [MAX_LEN];
    logic [COORD_W-1:0] snap_y_arr [MAX_LEN];

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_unpack
        assign snap_x_arr[i] = snap_x_flat[i*COORD_W +: COORD_W];
        assign snap_y_arr[i] = snap_y_flat[i*COORD_W +: COORD_W];
    end

    // ------------------------------------------------------------------
    // Rebuild FSM
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic               do_swap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            seg_q   <= seg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        seg_d   = seg_q;
        do_swap = 1'b0;
        // A new frame_start always wins. A half-built back buffer is simply rebuilt,
        // and a pending swap is dropped.
        if (frame_start) begin
            state_d = StClear;
            row_d   = '0;
            seg_d   = '0;
        end else begin
            case (state_q)
                StIdle: ;
                StClear: begin
                    if (row_q == ROW_LAST) begin
                        state_d = (snap_len == '0) ? StSwap : StLoad;
                        seg_d   = '0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
                StLoad: begin
                    if (LEN_W'(seg_q) + 1'b1 == snap_len) begin
                        state_d = StSwap;
                    end else begin
                        seg_d = seg_q + 1'b1;
                    end
                end
                StSwap: begin
                    do_swap = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);

    // ------------------------------------------------------------------
    // Double-buffered bitmaps. front_sel=0 means bm0 is shown and bm1 is rebuilt.
    // ------------------------------------------------------------------
    logic [GRID_W-1:0]  bm0 [GRID_H];
    logic [GRID_W-1:0]  bm1 [GRID_H];
    logic               front_sel;
    logic [COORD_W-1:0] seg_x, seg_y;
    logic               seg_ok;

    assign seg_x  = snap_x_arr[seg_q];
    assign seg_y  = snap_y_arr[seg_q];
    // Off-grid segments are dropped here, so they never alias onto a real cell
    assign seg_ok = ({1'b0, seg_x} < GRID_W_C) && ({1'b0, seg_y} < GRID_H_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < GRID_H; r++) begin
                bm0[r] <= '0;
                bm1[r] <= '0;
            end
        end else if (state_q == StClear) begin
            if (front_sel) bm0[row_q] <= '0;
            else           bm1[row_q] <= '0;
        end else if (state_q == StLoad && seg_ok) begin
            if (front_sel) bm0[seg_y][seg_x] <= 1'b1;
            else           bm1[seg_y][seg_x] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Front-side state, promoted from the snapshot on swap
    // ------------------------------------------------------------------
    logic [1:0]         front_state;
    logic [COORD_W-1:0] front_ax, front_ay, front_hx, front_hy;
    logic               front_has_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel      <= 1'b0;
            front_state    <= GS_OFF;
            front_ax       <= '0;
            front_ay       <= '0;
            front_hx       <= '0;
            front_hy       <= '0;
            front_has_head <= 1'b0;
        end else if (do_swap) begin
            front_sel      <= ~front_sel;
            front_state    <= snap_state;
            front_ax       <= snap_ax;
            front_ay       <= snap_ay;
            front_hx       <= snap_x_arr[0];
            front_hy       <= snap_y_arr[0];
            front_has_head <= (snap_len != '0);
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline, stage 1: cell coordinates
    // ------------------------------------------------------------------
    logic [9:0]         cx_full;
    logic [8:0]         cy_full;
    logic [COORD_W-1:0] s1_cx, s1_cy;
    logic               s1_in_grid, s1_act;

    assign cx_full = x_addr >> CELL_LOG2;
    assign cy_full = y_addr >> CELL_LOG2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_cx      <= '0;
            s1_cy      <= '0;
            s1_in_grid <= 1'b0;
            s1_act     <= 1'b0;
        end else begin
            s1_cx      <= cx_full[COORD_W-1:0];
            s1_cy      <= cy_full[COORD_W-1:0];
            s1_in_grid <= (cx_full < 10'(GRID_W)) && (cy_full < 9'(GRID_H));
            s1_act     <= ~rdn;
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline, stage 2: bitmap lookup and colour select
    // ------------------------------------------------------------------
    logic [GRID_W-1:0] front_row;
    logic              front_bit, is_head, is_apple;
    logic [11:0]       color_d;

    assign front_row = front_sel ? bm1[s1_cy] : bm0[s1_cy];
    assign front_bit = front_row[s1_cx];
    assign is_head   = front_has_head && (s1_cx == front_hx) && (s1_cy == front_hy);
    assign is_apple  = (s1_cx == front_ax) && (s1_cy == front_ay);

    always_comb begin
        color_d = 12'h000;
        if (s1_act && s1_in_grid) begin
            case (front_state)
                GS_RUN: begin
                    if (is_head)        color_d = HEAD_C;
                    else if (is_apple)  color_d = APPLE_C;
                    else if (front_bit) color_d = BODY_C;
                    else                color_d = BG_C;
                end
                GS_DIE:  color_d = front_bit ? DIE_C : BG_C;
                GS_INIT: color_d = INIT_C;
                default: color_d = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_color <= 12'h000;
            pix_valid <= 1'b0;
        end else begin
            pix_color <= color_d;
            pix_valid <= s1_act;
        end
    end

endmodule
